// File: rtl/idu_stage_buf.sv
// Decode-stage output buffer: DEPTH-entry valid/ready FIFO toward EXU
// with flush, freeze, load-use bubble insertion and a stall counter.
module idu_stage_buf #(
  parameter int CPU_WIDTH      = 32,
  parameter int DEC_W          = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CPU_WIDTH-1:0]      in_pc,
  input  logic [CPU_WIDTH-1:0]      in_inst,
  input  logic [DEC_W-1:0]          in_dec,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_WIDTH-1:0]      out_pc,
  output logic [CPU_WIDTH-1:0]      out_inst,
  output logic [DEC_W-1:0]          out_dec,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_ren,
  output logic                      hazard_stall,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      pc;
    logic [CPU_WIDTH-1:0]      inst;
    logic [DEC_W-1:0]          dec;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  ent_t          wdat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          live;
  logic          full;
  logic          empty;
  logic          hazard;
  logic          push;
  logic          pop;

  assign live  = enable & ~flush;
  assign head  = mem[rd_ptr];
  assign full  = (occ == OW'(DEPTH));
  assign empty = (occ == '0);

  // Load result not yet available: hold the consumer back one bubble
  assign hazard = ~empty & ex_mem_ren & (ex_rd != '0)
                & ((head.rs1 == ex_rd) | (head.rs2 == ex_rd));

  // rst_n term keeps in_ready low while reset is held
  assign in_ready     = rst_n & live & ~full;
  assign out_valid    = live & ~empty & ~hazard;
  assign hazard_stall = live & hazard;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign wdat.pc   = in_pc;
  assign wdat.inst = in_inst;
  assign wdat.dec  = in_dec;
  assign wdat.rs1  = in_rs1;
  assign wdat.rs2  = in_rs2;

  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_dec   = head.dec;
  assign out_rs1   = head.rs1;
  assign out_rs2   = head.rs2;
  assign occupancy = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (enable) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wdat;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      occ <= occ + OW'(1);
        else if (pop && !push) occ <= occ - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard_stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idu_stage_buf.sv
// Directed table-driven bench for idu_stage_buf (DEPTH=2, CNT_W=4).
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_idu_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [63:0] in_dec;
  logic [4:0]  in_rs1, in_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [63:0] out_dec;
  logic [4:0]  out_rs1, out_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_ren, hazard_stall;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_stage_buf #(
    .CPU_WIDTH(32), .DEC_W(64), .REG_ADDR_WIDTH(5),
    .DEPTH(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_dec(in_dec), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_dec(out_dec),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .ex_rd(ex_rd),
    .ex_mem_ren(ex_mem_ren), .hazard_stall(hazard_stall),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit        en, fl, iv;
    bit [31:0] pc;
    bit [4:0]  rs1, rs2;
    bit        ordy;
    bit [4:0]  exrd;
    bit        exmr;
    bit        x_irdy, x_ovld;
    bit [31:0] x_pc;
    bit [1:0]  x_occ;
    bit        x_hz;
    bit [3:0]  x_sc;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];

  function automatic vec_t mk(
    bit en, bit fl, bit iv, bit [31:0] pc, bit [4:0] rs1,
    bit [4:0] rs2, bit ordy, bit [4:0] exrd, bit exmr,
    bit irdy, bit ovld, bit [31:0] xpc, bit [1:0] occ,
    bit hz, bit [3:0] sc);
    vec_t v;
    v.en = en; v.fl = fl; v.iv = iv; v.pc = pc;
    v.rs1 = rs1; v.rs2 = rs2; v.ordy = ordy;
    v.exrd = exrd; v.exmr = exmr;
    v.x_irdy = irdy; v.x_ovld = ovld; v.x_pc = xpc;
    v.x_occ = occ; v.x_hz = hz; v.x_sc = sc;
    return v;
  endfunction

  function automatic [31:0] inst_of(input [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  function automatic [63:0] dec_of(input [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit fl, input bit iv,
                       input bit [31:0] pc, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit ordy,
                       input bit [4:0] exrd, input bit exmr);
    enable = en; flush = fl; in_valid = iv;
    in_pc = pc; in_inst = inst_of(pc); in_dec = dec_of(pc);
    in_rs1 = rs1; in_rs2 = rs2; out_ready = ordy;
    ex_rd = exrd; ex_mem_ren = exmr;
  endtask

  initial begin
    // stream
    tv[0]  = mk(1,0,1,32'h00,1,2,1,0,0, 1,0,32'h00,0,0,0);
    tv[1]  = mk(1,0,1,32'h04,1,2,1,0,0, 1,1,32'h00,1,0,0);
    tv[2]  = mk(1,0,1,32'h08,1,2,1,0,0, 1,1,32'h04,1,0,0);
    tv[3]  = mk(1,0,0,32'h00,0,0,1,0,0, 1,1,32'h08,1,0,0);
    // backpressure / full
    tv[4]  = mk(1,0,1,32'h10,1,2,0,0,0, 1,0,32'h00,0,0,0);
    tv[5]  = mk(1,0,1,32'h14,1,2,0,0,0, 1,1,32'h10,1,0,0);
    tv[6]  = mk(1,0,1,32'h18,1,2,0,0,0, 0,1,32'h10,2,0,0);
    tv[7]  = mk(1,0,1,32'h18,1,2,1,0,0, 0,1,32'h10,2,0,0);
    tv[8]  = mk(1,0,1,32'h18,1,2,1,0,0, 1,1,32'h14,1,0,0);
    tv[9]  = mk(1,0,0,32'h00,0,0,1,0,0, 1,1,32'h18,1,0,0);
    // load-use on rs1
    tv[10] = mk(1,0,1,32'h20,5,6,0,0,0, 1,0,32'h00,0,0,0);
    tv[11] = mk(1,0,0,32'h00,0,0,1,5,1, 1,0,32'h00,1,1,0);
    tv[12] = mk(1,0,0,32'h00,0,0,1,5,0, 1,1,32'h20,1,0,1);
    // x0 never stalls
    tv[13] = mk(1,0,1,32'h24,0,0,0,0,0, 1,0,32'h00,0,0,1);
    tv[14] = mk(1,0,0,32'h00,0,0,0,0,1, 1,1,32'h24,1,0,1);
    tv[15] = mk(1,0,0,32'h00,0,0,1,0,1, 1,1,32'h24,1,0,1);
    // load-use on rs2
    tv[16] = mk(1,0,1,32'h28,3,9,0,0,0, 1,0,32'h00,0,0,1);
    tv[17] = mk(1,0,0,32'h00,0,0,1,9,1, 1,0,32'h00,1,1,1);
    tv[18] = mk(1,0,0,32'h00,0,0,1,9,0, 1,1,32'h28,1,0,2);
    // flush with full buffer, push and pop requested
    tv[19] = mk(1,0,1,32'h30,1,2,0,0,0, 1,0,32'h00,0,0,2);
    tv[20] = mk(1,0,1,32'h34,1,2,0,0,0, 1,1,32'h30,1,0,2);
    tv[21] = mk(1,1,1,32'h38,1,2,1,0,0, 0,0,32'h00,2,0,2);
    tv[22] = mk(1,0,0,32'h00,0,0,1,0,0, 1,0,32'h00,0,0,2);
    // freeze with pending hazard, flush ignored while frozen
    tv[23] = mk(1,0,1,32'h40,7,8,0,0,0, 1,0,32'h00,0,0,2);
    tv[24] = mk(0,1,1,32'h44,0,0,1,7,1, 0,0,32'h00,1,0,2);
    tv[25] = mk(0,1,1,32'h44,0,0,1,7,1, 0,0,32'h00,1,0,2);
    tv[26] = mk(0,1,1,32'h44,0,0,1,7,1, 0,0,32'h00,1,0,2);
    tv[27] = mk(1,0,0,32'h00,0,0,1,7,1, 1,0,32'h00,1,1,2);
    tv[28] = mk(1,0,0,32'h00,0,0,1,0,0, 1,1,32'h40,1,0,3);

    rst_n = 1'b0;
    drive(1,0,0,32'h0,0,0,0,0,0);
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_dec", out_dec, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].en, tv[i].fl, tv[i].iv, tv[i].pc, tv[i].rs1,
            tv[i].rs2, tv[i].ordy, tv[i].exrd, tv[i].exmr);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready),
          64'(tv[i].x_irdy));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid),
          64'(tv[i].x_ovld));
      chk($sformatf("v%0d_occ", i), 64'(occupancy),
          64'(tv[i].x_occ));
      chk($sformatf("v%0d_hazard", i), 64'(hazard_stall),
          64'(tv[i].x_hz));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt),
          64'(tv[i].x_sc));
      if (tv[i].x_ovld) begin
        chk($sformatf("v%0d_out_pc", i), 64'(out_pc),
            64'(tv[i].x_pc));
        chk($sformatf("v%0d_out_inst", i), 64'(out_inst),
            64'(inst_of(tv[i].x_pc)));
        chk($sformatf("v%0d_out_dec", i), out_dec,
            dec_of(tv[i].x_pc));
      end
    end

    // saturation: hazard held for 20 cycles from stall_cnt=3
    @(negedge clk);
    drive(1,0,1,32'h50,4,0,0,0,0);
    @(negedge clk);
    drive(1,0,0,32'h00,0,0,1,4,1);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    chk("sat_hazard", 64'(hazard_stall), 64'd1);
    chk("sat_out_valid", 64'(out_valid), 64'd0);
    chk("sat_occ", 64'(occupancy), 64'd1);
    chk("sat_head_pc", 64'(out_pc), 64'h50);

    // asynchronous reset in mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_hazard", 64'(hazard_stall), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_out_inst", 64'(out_inst), 64'd0);
    chk("arst_out_dec", out_dec, 64'd0);
    chk("arst_out_rs1", 64'(out_rs1), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,1,32'h60,0,0,0,0,0);
    #1;
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_out_valid0", 64'(out_valid), 64'd0);
    @(negedge clk);
    drive(1,0,0,32'h00,0,0,1,0,0);
    #1;
    chk("post_out_valid1", 64'(out_valid), 64'd1);
    chk("post_out_pc", 64'(out_pc), 64'h60);
    chk("post_occ", 64'(occupancy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
